// File: rtl/perf_pkg.sv
// perf_pkg: shared constants and helpers for the performance counter bank.
// Channel indices name the conventional event assignment at the CPU top
// level; the bank itself treats every channel identically.
package perf_pkg;

  // Conventional channel assignment
  localparam int CH_TOTAL      = 0;  // every enabled cycle
  localparam int CH_COND_TAKEN = 1;  // taken conditional branches
  localparam int CH_UNCOND     = 2;  // unconditional jumps
  localparam int CH_SYSCALL    = 3;  // syscalls

  // Default geometry of the bank
  localparam int DEFAULT_CHANNELS = 4;
  localparam int DEFAULT_WIDTH    = 32;

  // Ceiling log2 of n. Returns at least 1 so the result is always usable
  // as a vector width, even for a single-channel bank.
  function automatic int sel_bits(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// perf_counter: one WIDTH-bit event counter with synchronous clear and a
// sticky overflow flag.
//  - SATURATE = 0: all-ones + 1 wraps to zero.
//  - SATURATE = 1: all-ones + 1 holds at all-ones.
// Either way the attempted increment past all-ones sets ovf, which then
// stays set until clr or reset. clr beats inc on the same edge.
module perf_counter #(
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  logic at_max;

  assign at_max = &count;

  // Count qualified events; clear has priority; overflow is sticky
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (at_max) begin
        ovf   <= 1'b1;
        count <= (SATURATE != 0) ? count : '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: CHANNELS event counters qualified by the PC enable,
// a button-driven display selector and a combinational output mux that
// feeds the seven-segment driver.
//
// Optional feature macro: PERF_SNAPSHOT_EN
//   defined   - a shadow register per channel; snap loads every shadow on
//               the same edge (coherent view across channels) and dout
//               shows the shadow of the selected channel.
//   undefined - no shadows; snap is ignored and dout shows the live
//               counter of the selected channel.
//
// The port called "event" in the block description is named "events"
// here because "event" is a reserved word in SystemVerilog.
//
// next is assumed already synchronised and debounced by the top level.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SATURATE = 0,
  parameter int SEL_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] events,
  input  logic                clr,
  input  logic                snap,
  input  logic                next,
  output logic [SEL_BITS-1:0] sel,
  output logic [WIDTH-1:0]    dout,
  output logic [CHANNELS-1:0] ovf
);

  // Live counter values, one per channel
  logic [WIDTH-1:0]    live [CHANNELS];
  // Per-channel increment: event strobe gated by the PC enable so halted
  // cycles are never counted
  logic [CHANNELS-1:0] inc;
  // Registered copy of the button level for rising-edge detection
  logic                next_q;
  logic                next_rise;
  logic [SEL_BITS-1:0] sel_last;

  assign inc       = events & {CHANNELS{en}};
  assign next_rise = next & ~next_q;
  assign sel_last  = SEL_BITS'(CHANNELS - 1);

  // One counter per channel
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    perf_counter #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[g]),
      .clr   (clr),
      .count (live[g]),
      .ovf   (ovf[g])
    );
  end

  // Advance the selector once per rising edge of next, wrapping at
  // CHANNELS-1 so non-power-of-two banks never select a missing channel.
  // clr deliberately leaves the selection alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_q <= 1'b0;
      sel    <= '0;
    end else begin
      next_q <= next;
      if (next_rise) begin
        if (sel == sel_last) begin
          sel <= '0;
        end else begin
          sel <= sel + SEL_BITS'(1);
        end
      end
    end
  end

`ifdef PERF_SNAPSHOT_EN
  // Shadow copies of every counter
  logic [WIDTH-1:0] shadow [CHANNELS];

  // Capture all pre-increment live values on the same edge; clr wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
      end
    end else if (snap) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= live[i];
      end
    end
  end

  // Display the frozen shadow of the selected channel
  always_comb begin
    dout = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_BITS'(i)) begin
        dout = shadow[i];
      end
    end
  end
`else
  // snap has no function without shadow registers
  logic unused_snap;
  assign unused_snap = snap;

  // Display the live counter of the selected channel
  always_comb begin
    dout = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_BITS'(i)) begin
        dout = live[i];
      end
    end
  end
`endif

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised bank of event counters counting processor events (total cycles, taken conditional branches, unconditional jumps, syscalls, ...) on the divided CPU clock, gated by the PC enable so halted cycles are not counted. Replaces the fixed three-counter cycle statistics block and its display switcher with one block of `CHANNELS` counters. It adds:
- a button-driven display selector;
- sticky overflow flags;
- optional wrap or saturate arithmetic;
- optional atomic snapshot of all counters.

`dout` feeds the seven-segment display driver directly.

## Interface
Parameters:
- `CHANNELS`, 4: number of counters, 1..16.
- `WIDTH`, 32: counter width in bits, 8..64.
- `SATURATE`, 0: 0 = counters wrap modulo 2^`WIDTH`; 1 = counters hold at all-ones.
- `SEL_BITS`, 4: width of selector index; must satisfy 2^`SEL_BITS` >= `CHANNELS`.

Ports:
- `clk` in 1: CPU clock (divided clock `clk_N` at top level).
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: count qualifier; tie to `pcen`.
- `event` in `CHANNELS`: per-channel event strobes, level-sampled each edge; top level ties `event[0]`=1 for total cycles.
- `clr` in 1: synchronous clear of all counters, snapshots and flags.
- `snap` in 1: capture all live counters into shadow registers.
- `next` in 1: raw button level; each rising edge advances the selector.
- `sel` out `SEL_BITS`: currently displayed channel.
- `dout` out `WIDTH`: value of the selected channel.
- `ovf` out `CHANNELS`: sticky overflow flags.

## Operation
- **Counting.** Counter i increments on an edge where `en` & `event[i]` = 1. Otherwise it holds.
- **Wrap mode (`SATURATE`=0).** All-ones + 1 → 0 and sets `ovf[i]`.
- **Saturate mode (`SATURATE`=1).** All-ones + 1 stays all-ones and sets `ovf[i]`.
- **Overflow flags.** `ovf[i]` stays set until `clr` or reset.
- **Priority:** `clr` > increment. `clr` wins if it is asserted together with events, and the counter reads 0 after that edge (no increment).
- **Selector.** `next` is registered once into `next_q`. A rising edge is `next` & ~`next_q`.
  - Each rising edge sets `sel` ← (`sel`+1) mod `CHANNELS`, so `CHANNELS`-1 wraps to 0; non-power-of-two counts are handled.
  - Holding `next` high advances `sel` exactly once.
  - `clr` does not change `sel`.
- **`dout` source.** `dout` is a combinational mux over `sel` of the source selected by the configuration (see Configuration).
- **Reset** (`rst`=0, immediate):
  - all counters, snapshots, `ovf` = 0;
  - `sel` = 0, `next_q` = 0;
  - `dout` = 0.

## Timing
- **Increment latency.** An event sampled at edge k is visible on `dout` after edge k (same cycle, combinational mux). There is no extra pipeline stage.
- **Selector latency.** A `next` rising edge sampled at edge k updates `sel`/`dout` after edge k. Minimum one clock of low between presses.
- **Snapshot timing.** `snap` at edge k captures counter values as they were before edge k's increment, i.e. pre-increment values.
- **`snap` and `clr` together.** Snapshots are cleared; `clr` wins.
- **Reset mid-count.** Reset takes effect immediately. The first count after deassertion occurs at the first edge with `en` & `event` high.
- **Single clock domain.** `next` comes from a button. Synchronisation and debouncing belong to the top level; the block assumes `next` is synchronous to `clk`.

## Configuration
- **Macro:** `PERF_SNAPSHOT_EN`.
- **Defined:**
  - `CHANNELS` × `WIDTH` shadow registers exist.
  - `dout` muxes the snapshot of channel `sel`.
  - `snap` loads all shadows in the same edge, giving an atomic, coherent view across channels.
- **Undefined:**
  - no shadow registers;
  - `snap` is ignored;
  - `dout` muxes the live counter of channel `sel`.

## Structure
- **Package `perf_pkg`:**
  - channel index constants `CH_TOTAL`=0, `CH_COND_TAKEN`=1, `CH_UNCOND`=2, `CH_SYSCALL`=3;
  - default `WIDTH`/`CHANNELS` constants;
  - a `sel_bits(n)` ceil-log2 function.
- **Sub-module `perf_counter`:**
  - one `WIDTH`-bit counter with inc/clr inputs, `SATURATE` parameter and sticky `ovf` output;
  - generated `CHANNELS` times.
- **Top of `perf_counter_bank`:** selector, edge detect, shadow registers and output mux.

## Test plan
1. **Reset and basic counting.** Reset, then 10 edges with `en`=1, `event`=4'b0001. Expect ch0=10, others 0, `ovf`=0.
2. **Halt gating.** `en`=0 for 5 edges with `event`=4'b1111. Expect no counter changes.
3. **Wrap and saturate at `WIDTH`=8.**
   - `SATURATE`=0: 256 events → ch0=0, `ovf[0]`=1.
   - `SATURATE`=1: 300 events → ch0=255, `ovf[0]`=1.
   - Then `clr` → counter 0, `ovf` 0.
4. **Selector wrap at `CHANNELS`=3.** Hold `next` high 4 cycles → `sel`=1. Three separate presses from 0 → sel 1, 2, 0.
5. **Snapshot (`PERF_SNAPSHOT_EN` defined).**
   - ch1=7; assert `snap` on an edge with `event[1]`=1 → snapshot=7, live=8, `dout` (`sel`=1) = 7.
   - `snap`+`clr` same edge → `dout`=0.
6. **Asynchronous reset mid-count.** Pull `rst` low between edges while counters are nonzero. `dout`, `sel`, `ovf` must go 0 before the next `clk` edge.
